regfile_decoded: RTL and testbench
==================================

// Module: regfile_decoded
// PURPOSE
//  Parametrised register file; write port selected by a one-hot address decoder.
//  Generalises the fixed 5-to-32 decoder to any address width and register depth.
//  Adds storage, a hardwired-zero register option, write-to-read bypass and a registered one-hot write trace.
//  Sits in the lab datapath between the writeback stage and the operand-read stage.
// PARAMETERS
//  AW        5   address width in bits
//  DEPTH     32  number of registers, 1..2**AW; addresses >= DEPTH are out of range
//  DW        32  data width in bits
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes
//  BYPASS    1   1: a read of the address being written this cycle returns wdata
// PORTS
//  clk      in   1      single clock; all state updates on rising edge
//  rst      in   1      synchronous, active-high reset
//  we       in   1      write enable
//  waddr    in   AW     write address
//  wdata    in   DW     write data
//  raddr_a  in   AW     read port A address
//  rdata_a  out  DW     read port A data (combinational)
//  raddr_b  in   AW     read port B address
//  rdata_b  out  DW     read port B data (combinational)
//  wsel_q   out  DEPTH  registered one-hot of the last accepted write; 0 if no write that cycle
// BEHAVIOUR
//  - Reset: on the clk edge with rst=1, all registers <= 0 and wsel_q <= 0.
//    rst beats we; a write in the reset cycle is dropped.
//    After reset, both read ports return 0 for every address.
//  - Decode: sel = one-hot(waddr) gated by we.
//    sel is all-zero when waddr >= DEPTH.
//    sel is all-zero when ZERO_REG=1 and waddr==0.
//  - Write: on the clk edge with rst=0, reg[i] <= wdata for the single i where sel[i]=1.
//    Latency is 1 cycle: the written value is visible from stored state on the next cycle.
//  - wsel_q <= sel every non-reset cycle.
//    It is exactly one-hot after an accepted write, else zero. It is never multi-hot.
//  - Read, per port, independently:
//    - Address >= DEPTH -> 0.
//    - ZERO_REG=1 and address 0 -> 0.
//    - BYPASS=1 and sel[addr]=1 -> wdata in the same cycle.
//    - Otherwise -> reg[addr].
//  - Both ports may read the same address, and both may bypass in the same cycle.
//  - A dropped write (out of range, reg 0, or reset cycle) never bypasses.
//  - Back-to-back writes to one address: the last one wins; each is visible the following cycle.
//  - No internal FSM. The state is the register array plus wsel_q.
// STRUCTURE
//  - Shared package regfile_pkg: default AW/DEPTH/DW constants and the ZERO_ADDR constant (0).
//  - One sub-module: decoder_onehot.
//    - Parameters: AW, DEPTH. Ports: en, addr[AW] -> out[DEPTH].
//    - Purely combinational; zero output for out-of-range addresses or en=0.
//  - The top level instantiates decoder_onehot for the write path. The register array, read muxes and bypass live in the top level.
// TESTING
//  1. Reset: assert rst for 2 cycles, then sweep raddr_a/b over 0..31 -> all rdata=0, wsel_q=0.
//  2. Write then read: we=1, waddr=5, wdata=32'hDEADBEEF.
//     -> wsel_q=32'h20 the next cycle.
//     -> raddr_a=5 reads 32'hDEADBEEF from the next cycle onward.
//  3. Zero register: we=1, waddr=0, wdata=32'hFFFFFFFF.
//     -> rdata_a(0)=0 (including the bypass cycle), wsel_q=0.
//  4. Bypass: same cycle we=1, waddr=7, wdata=32'h1234, raddr_a=raddr_b=7.
//     -> both rdata=32'h1234 combinationally, before the edge.
//  5. Reset mid-write: rst=1 with we=1, waddr=3, wdata=32'hA5A5 -> reg3 reads 0 afterwards, wsel_q=0.
//  6. Out of range: AW=5, DEPTH=20; write waddr=25 -> no register changes, wsel_q=0, reading 25 returns 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the decoded register file and its write decoder.
package regfile_pkg;

  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DEPTH_DEF = 32;
  localparam int unsigned DW_DEF    = 32;
  localparam int unsigned ZERO_ADDR = 0;

endpackage

// File: rtl/decoder_onehot.sv
// Combinational one-hot address decoder; all-zero when disabled or out of range.
module decoder_onehot
  import regfile_pkg::*;
#(
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             en,
  input  logic [AW-1:0]    addr,
  output logic [DEPTH-1:0] out
);

  // Addresses >= DEPTH match no output bit, so they decode to zero.
  always_comb begin
    out = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (en && (addr == AW'(i))) out[i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_decoded.sv
// Register file with one-hot decoded write port, optional hardwired zero
// register, write-to-read bypass and a registered trace of the accepted write.
module regfile_decoded
  import regfile_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [DW-1:0]    wdata,
  input  logic [AW-1:0]    raddr_a,
  output logic [DW-1:0]    rdata_a,
  input  logic [AW-1:0]    raddr_b,
  output logic [DW-1:0]    rdata_b,
  output logic [DEPTH-1:0] wsel_q
);

  logic [DW-1:0]    regs [DEPTH];
  logic [DEPTH-1:0] sel;
  logic             zero_hit;
  logic             wr_en;
  logic [AW-1:0]    raddr [2];
  logic [DW-1:0]    rdata [2];

  // Writes to the hardwired zero register and writes during reset are dropped
  // at the decoder, so they neither update state nor bypass.
  assign zero_hit = ZERO_REG && (waddr == AW'(ZERO_ADDR));
  assign wr_en    = we && !rst && !zero_hit;

  decoder_onehot #(
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_wdec (
    .en   (wr_en),
    .addr (waddr),
    .out  (sel)
  );

  // Storage update and write trace; reset clears everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      wsel_q <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (sel[i]) regs[i] <= wdata;
      end
      wsel_q <= sel;
    end
  end

  assign raddr[0] = raddr_a;
  assign raddr[1] = raddr_b;

  // Per-port read mux with bypass; out-of-range and zero-register reads give 0.
  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p] = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (raddr[p] == AW'(i)) begin
          if (BYPASS && sel[i]) rdata[p] = wdata;
          else                  rdata[p] = regs[i];
        end
      end
      if (ZERO_REG && (raddr[p] == AW'(ZERO_ADDR))) rdata[p] = '0;
    end
  end

  assign rdata_a = rdata[0];
  assign rdata_b = rdata[1];

endmodule

// File: tb/tb_regfile_decoded.sv
// Self-checking bench: a full-depth instance and a DEPTH=20 instance share one
// stimulus stream and are compared every cycle against array-based models.
module tb_regfile_decoded;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [4:0]  raddr_a;
  logic [4:0]  raddr_b;
  logic [31:0] rdata_a0, rdata_b0, rdata_a1, rdata_b1;
  logic [31:0] wsel_q0;
  logic [19:0] wsel_q1;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  logic [31:0] mem0 [32];
  logic [31:0] mem1 [20];
  logic [31:0] exp_ws0, exp_ws1;

  regfile_decoded #(.AW(5), .DEPTH(32), .DW(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut0 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a0), .raddr_b(raddr_b), .rdata_b(rdata_b0),
    .wsel_q(wsel_q0)
  );

  regfile_decoded #(.AW(5), .DEPTH(20), .DW(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr_a(raddr_a), .rdata_a(rdata_a1), .raddr_b(raddr_b), .rdata_b(rdata_b1),
    .wsel_q(wsel_q1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Expected read: reg 0 and out-of-range are zero; a live accepted write bypasses.
  function automatic logic [31:0] mread(input int depth, input int a);
    if (a == 0 || a >= depth) return 32'h0;
    if (we && !rst && a == int'(waddr)) return wdata;
    return (depth == 32) ? mem0[a] : mem1[a];
  endfunction

  function automatic logic [31:0] mwsel(input int depth);
    if (rst || !we || waddr == 5'd0 || int'(waddr) >= depth) return 32'h0;
    return 32'h1 << waddr;
  endfunction

  // Reference state update at each rising edge.
  always @(posedge clk) begin
    exp_ws0 = mwsel(32);
    exp_ws1 = mwsel(20);
    if (rst) begin
      for (int i = 0; i < 32; i++) mem0[i] = 32'h0;
      for (int i = 0; i < 20; i++) mem1[i] = 32'h0;
    end else if (we && waddr != 5'd0) begin
      mem0[waddr] = wdata;
      if (waddr < 5'd20) mem1[waddr] = wdata;
    end
  end

  // Compare process: all outputs of both instances, mid-cycle.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rdata_a_d32", rdata_a0, mread(32, int'(raddr_a)));
      chk("rdata_b_d32", rdata_b0, mread(32, int'(raddr_b)));
      chk("rdata_a_d20", rdata_a1, mread(20, int'(raddr_a)));
      chk("rdata_b_d20", rdata_b1, mread(20, int'(raddr_b)));
      chk("wsel_q_d32", wsel_q0, exp_ws0);
      chk("wsel_q_d20", 32'(wsel_q1), exp_ws1);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] ra, input logic [4:0] rb);
    @(posedge clk);
    #1;
    rst = r; we = w; waddr = wa; wdata = wd; raddr_a = ra; raddr_b = rb;
    #2;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr_a = '0; raddr_b = '0;

    // Reset for two edges, then sweep both read ports.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd31);
    chk_en = 1'b1;
    chk("reset_wsel", wsel_q0, 32'h0);
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      chk("reset_sweep_a", rdata_a0, 32'h0);
    end

    // Write then read.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("wr5_wsel", wsel_q0, 32'h20);
    chk("wr5_read", rdata_a0, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    chk("wr5_read_later", rdata_a0, 32'hDEADBEEF);

    // Zero register ignores writes, including the bypass cycle.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
    chk("zero_bypass", rdata_a0, 32'h0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    chk("zero_wsel", wsel_q0, 32'h0);
    chk("zero_read", rdata_a0, 32'h0);

    // Same-cycle bypass on both ports.
    drive(1'b0, 1'b1, 5'd7, 32'h1234, 5'd7, 5'd7);
    chk("bypass_a", rdata_a0, 32'h1234);
    chk("bypass_b", rdata_b0, 32'h1234);

    // Back-to-back writes to one address; last wins.
    drive(1'b0, 1'b1, 5'd3, 32'h1111, 5'd3, 5'd7);
    drive(1'b0, 1'b1, 5'd3, 32'h2222, 5'd7, 5'd5);
    chk("b2b_first", rdata_b0, 32'hDEADBEEF);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3);
    chk("b2b_last", rdata_a0, 32'h2222);

    // Reset with a write pending: write is dropped and state cleared.
    drive(1'b1, 1'b1, 5'd3, 32'hA5A5, 5'd3, 5'd3);
    chk("rst_no_bypass", rdata_a0, 32'h2222);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);
    chk("rst_reg3", rdata_a0, 32'h0);
    chk("rst_reg5", rdata_b0, 32'h0);
    chk("rst_wsel", wsel_q0, 32'h0);

    // Out of range on the DEPTH=20 instance.
    drive(1'b0, 1'b1, 5'd25, 32'hCAFEF00D, 5'd25, 5'd25);
    chk("oor_bypass_d20", rdata_a1, 32'h0);
    chk("inrange_bypass_d32", rdata_a0, 32'hCAFEF00D);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd25, 5'd19);
    chk("oor_wsel_d20", 32'(wsel_q1), 32'h0);
    chk("oor_read_d20", rdata_a1, 32'h0);
    chk("wsel_d32_25", wsel_q0, 32'h02000000);
    drive(1'b0, 1'b1, 5'd19, 32'h0BADCAFE, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd19, 5'd0);
    chk("top_wsel_d20", 32'(wsel_q1), 32'h00080000);
    chk("top_read_d20", rdata_a1, 32'h0BADCAFE);

    // Randomised traffic with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      drive(($urandom_range(63) == 0), ($urandom_range(3) != 0), 5'($urandom_range(31)),
            $urandom, 5'($urandom_range(31)), 5'($urandom_range(31)));
    end

    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
